// File: rtl/spi_controller.sv
// SPI mode-0 controller: sends one 16-bit frame {rw, addr, wr_data} MSB first.
// It captures the last 8 CIPO bits of the frame into rd_data.
module spi_controller #(
    parameter int unsigned HALF_PERIOD = 4,
    parameter int unsigned GAP_CYCLES  = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       rw,
    input  logic [6:0] addr,
    input  logic [7:0] wr_data,
    output logic       busy,
    output logic       done,
    output logic [7:0] rd_data,
    output logic       nCS,
    output logic       SCLK,
    output logic       COPI,
    input  logic       CIPO
);

    localparam int unsigned CNT_W   = 8;
    localparam int unsigned BIT_W   = 4;
    localparam int unsigned FRAME_W = 16;
    localparam int unsigned RD_W    = 8;

    localparam logic [CNT_W-1:0] HP_LAST  = CNT_W'(HALF_PERIOD - 1);
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYCLES - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(FRAME_W - 1);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        SHIFT,
        GAP
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [BIT_W-1:0]   bit_cnt;
    logic [FRAME_W-2:0] tx;
    logic [RD_W-1:0]    rx;

    // SCLK doubles as the phase flag inside SHIFT: 1 = high half, 0 = low half.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_cnt <= '0;
            tx      <= '0;
            rx      <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            rd_data <= '0;
            nCS     <= 1'b1;
            SCLK    <= 1'b0;
            COPI    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        // MSB (rw) goes straight to COPI; the rest waits in tx.
                        tx      <= {addr, wr_data};
                        COPI    <= rw;
                        nCS     <= 1'b0;
                        SCLK    <= 1'b0;
                        busy    <= 1'b1;
                        cnt     <= '0;
                        bit_cnt <= '0;
                        state   <= SETUP;
                    end
                end

                SETUP: begin
                    if (cnt == HP_LAST) begin
                        cnt   <= '0;
                        SCLK  <= 1'b1;
                        rx    <= {rx[RD_W-2:0], CIPO};
                        state <= SHIFT;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end

                SHIFT: begin
                    if (cnt == HP_LAST) begin
                        cnt <= '0;
                        if (SCLK) begin
                            // tx drains to zero, so the 16th falling edge leaves COPI low.
                            SCLK <= 1'b0;
                            COPI <= tx[FRAME_W-2];
                            tx   <= {tx[FRAME_W-3:0], 1'b0};
                        end else if (bit_cnt == BIT_LAST) begin
                            bit_cnt <= '0;
                            nCS     <= 1'b1;
                            state   <= GAP;
                        end else begin
                            bit_cnt <= bit_cnt + BIT_W'(1);
                            SCLK    <= 1'b1;
                            rx      <= {rx[RD_W-2:0], CIPO};
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end

                GAP: begin
                    if (cnt == GAP_LAST) begin
                        cnt     <= '0;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        rd_data <= rx;
                        state   <= IDLE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_controller.sv
// Self-checking bench for spi_controller: two instances (4/8 and 2/1 timing),
// a mode-0 target model on CIPO, and frame-level expectations from the timing rules.
module tb_spi_controller;

    logic clk = 1'b0;
    logic rst_n;

    logic       start_a, rw_a, busy_a, done_a, ncs_a, sclk_a, copi_a, cipo_a;
    logic [6:0] addr_a;
    logic [7:0] wd_a, rd_a;
    logic       start_b, rw_b, busy_b, done_b, ncs_b, sclk_b, copi_b, cipo_b;
    logic [6:0] addr_b;
    logic [7:0] wd_b, rd_b;

    logic [15:0] resp_a = 16'h0;
    logic [15:0] resp_b = 16'h0;
    logic [4:0]  rise_a = 5'd0;
    logic [4:0]  rise_b = 5'd0;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    spi_controller #(.HALF_PERIOD(4), .GAP_CYCLES(8)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .rw(rw_a), .addr(addr_a),
        .wr_data(wd_a), .busy(busy_a), .done(done_a), .rd_data(rd_a),
        .nCS(ncs_a), .SCLK(sclk_a), .COPI(copi_a), .CIPO(cipo_a)
    );

    spi_controller #(.HALF_PERIOD(2), .GAP_CYCLES(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .rw(rw_b), .addr(addr_b),
        .wr_data(wd_b), .busy(busy_b), .done(done_b), .rd_data(rd_b),
        .nCS(ncs_b), .SCLK(sclk_b), .COPI(copi_b), .CIPO(cipo_b)
    );

    // Target model: presents resp MSB first, one bit per SCLK rising edge.
    always @(posedge sclk_a or posedge ncs_a)
        if (ncs_a) rise_a <= 5'd0;
        else       rise_a <= rise_a + 5'd1;
    always @(posedge sclk_b or posedge ncs_b)
        if (ncs_b) rise_b <= 5'd0;
        else       rise_b <= rise_b + 5'd1;
    assign cipo_a = (rise_a < 5'd16) ? resp_a[4'(5'd15 - rise_a)] : 1'b0;
    assign cipo_b = (rise_b < 5'd16) ? resp_b[4'(5'd15 - rise_b)] : 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit sel, input logic s, input logic r,
                         input logic [6:0] a, input logic [7:0] d);
        if (sel) begin
            start_b = s; rw_b = r; addr_b = a; wd_b = d;
        end else begin
            start_a = s; rw_a = r; addr_a = a; wd_a = d;
        end
    endtask

    // One frame; ign1/ign2 are cycle numbers at which a competing start is pulsed.
    task automatic run_frame(input bit sel, input logic rw, input logic [6:0] addr,
                             input logic [7:0] wd, input logic [15:0] resp,
                             input int ign1, input int ign2);
        int hp, gap, exp_done, rises, lows, highs, dones, done_cyc, gap_err, busy_err;
        logic [15:0] bits, frame;
        logic [7:0]  rd_at_done;
        logic        p_sclk, s_ncs, s_sclk, s_copi, s_done, s_busy;
        hp       = sel ? 2 : 4;
        gap      = sel ? 1 : 8;
        exp_done = 1 + 33 * hp + gap;
        frame    = {rw, addr, wd};
        rises = 0; lows = 0; highs = 0; dones = 0; done_cyc = -1;
        gap_err = 0; busy_err = 0; bits = 16'h0; rd_at_done = 8'h0; p_sclk = 1'b0;
        if (sel) resp_b = resp; else resp_a = resp;
        @(negedge clk);
        drive(sel, 1'b1, rw, addr, wd);
        @(negedge clk);
        drive(sel, 1'b0, rw, addr, wd);
        for (int cyc = 1; cyc <= exp_done + 3; cyc++) begin
            if (cyc > 1) @(negedge clk);
            s_ncs  = sel ? ncs_b  : ncs_a;
            s_sclk = sel ? sclk_b : sclk_a;
            s_copi = sel ? copi_b : copi_a;
            s_done = sel ? done_b : done_a;
            s_busy = sel ? busy_b : busy_a;
            if (cyc == ign1 || cyc == ign2) drive(sel, 1'b1, ~rw, ~addr, ~wd);
            else                            drive(sel, 1'b0, rw, addr, wd);
            if (s_sclk && !p_sclk) begin
                bits = {bits[14:0], s_copi};
                rises++;
            end
            p_sclk = s_sclk;
            if (!s_ncs) lows++;
            if (s_sclk) highs++;
            if (s_done) begin
                dones++;
                if (done_cyc < 0) begin
                    done_cyc   = cyc;
                    rd_at_done = sel ? rd_b : rd_a;
                end
            end
            if (cyc == 1) begin
                check("cs_first_cycle", 32'(s_ncs), 32'(0));
                check("copi_first_bit", 32'(s_copi), 32'(rw));
            end
            if (cyc > 33 * hp && cyc < exp_done && (s_copi !== 1'b0 || s_ncs !== 1'b1 || s_sclk !== 1'b0))
                gap_err++;
            if ((cyc < exp_done) !== s_busy) busy_err++;
        end
        check("frame_bits", 32'(bits), 32'(frame));
        check("sclk_rises", 32'(rises), 32'(16));
        check("ncs_low_cycles", 32'(lows), 32'(33 * hp));
        check("sclk_high_cycles", 32'(highs), 32'(16 * hp));
        check("done_count", 32'(dones), 32'(1));
        check("done_cycle", 32'(done_cyc), 32'(exp_done));
        check("rd_at_done", 32'(rd_at_done), 32'(resp[7:0]));
        check("gap_idle_lines", 32'(gap_err), 32'(0));
        check("busy_window", 32'(busy_err), 32'(0));
        check("rd_held", 32'(sel ? rd_b : rd_a), 32'(resp[7:0]));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int dones, hi_run, gaps, extra;
        logic        seen_low;
        logic [15:0] r;
        rst_n = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 7'h0, 8'h0);
        drive(1'b1, 1'b0, 1'b0, 7'h0, 8'h0);
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_ncs", 32'(ncs_a), 32'(1));
        check("rst_sclk", 32'(sclk_a), 32'(0));
        check("rst_copi", 32'(copi_a), 32'(0));
        check("rst_busy", 32'(busy_a), 32'(0));
        check("rst_done", 32'(done_a), 32'(0));
        check("rst_rd", 32'(rd_a), 32'(0));
        check("rst_ncs_b", 32'(ncs_b), 32'(1));
        check("rst_busy_b", 32'(busy_b), 32'(0));
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Directed write 0x84A5, then directed read returning 0x3C
        run_frame(1'b0, 1'b1, 7'h04, 8'hA5, 16'($urandom), -1, -1);
        r = {8'($urandom), 8'h3C};
        run_frame(1'b0, 1'b0, 7'h02, 8'($urandom), r, -1, -1);

        // Starts during a frame are ignored
        run_frame(1'b0, 1'b1, 7'h33, 8'hC3, 16'($urandom), 10, 100);

        // Reset at cycle 60 of a frame aborts it
        resp_a = 16'($urandom);
        @(negedge clk);
        drive(1'b0, 1'b1, 1'b1, 7'h11, 8'h5A);
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b1, 7'h11, 8'h5A);
        repeat (59) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_ncs", 32'(ncs_a), 32'(1));
        check("abort_sclk", 32'(sclk_a), 32'(0));
        check("abort_busy", 32'(busy_a), 32'(0));
        check("abort_copi", 32'(copi_a), 32'(0));
        check("abort_rd", 32'(rd_a), 32'(0));
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        extra = 0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (done_a) extra++;
        end
        check("abort_no_done", 32'(extra), 32'(0));
        run_frame(1'b0, 1'b1, 7'h5E, 8'h81, 16'($urandom), -1, -1);

        // start held high: back-to-back frames, nCS high GAP+1 cycles between them
        r = 16'($urandom);
        resp_a = r;
        @(negedge clk);
        drive(1'b0, 1'b1, 1'b0, 7'h2A, 8'h66);
        dones = 0; hi_run = 0; gaps = 0; seen_low = 1'b0;
        for (int c = 0; c < 4 * 141 && dones < 3; c++) begin
            @(negedge clk);
            if (done_a) begin
                dones++;
                check("b2b_rd", 32'(rd_a), 32'(r[7:0]));
                if (dones == 3) drive(1'b0, 1'b0, 1'b0, 7'h2A, 8'h66);
            end
            if (ncs_a) hi_run++;
            else begin
                if (seen_low && hi_run > 0) begin
                    check("b2b_gap", 32'(hi_run), 32'(9));
                    gaps++;
                end
                hi_run   = 0;
                seen_low = 1'b1;
            end
        end
        check("b2b_dones", 32'(dones), 32'(3));
        check("b2b_gaps", 32'(gaps), 32'(2));
        extra = 0;
        for (int c = 0; c < 150; c++) begin
            @(negedge clk);
            if (done_a) extra++;
        end
        check("b2b_no_queue", 32'(extra), 32'(0));
        check("b2b_idle_ncs", 32'(ncs_a), 32'(1));

        // Fast timing instance: directed then randomized frames on both instances
        run_frame(1'b1, 1'b1, 7'h7F, 8'h00, 16'hFFFF, -1, -1);
        for (int i = 0; i < 12; i++) begin
            run_frame(1'(i % 2), 1'($urandom), 7'($urandom), 8'($urandom),
                      16'($urandom), -1, -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/spi_controller.md
SPI_CONTROLLER -- requirements
Module: spi_controller

Interface
REQ-001 SHALL have parameter HALF_PERIOD, default 4, giving clk cycles per SCLK half-period; legal range 2..255.
REQ-002 SHALL have parameter GAP_CYCLES, default 8, giving clk cycles nCS is held high after each frame before done; legal range 1..255.
REQ-003 clk  input  1  single clock; all logic on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 start  input  1  request pulse; accepted only in IDLE.
REQ-006 rw  input  1  1 = write frame, 0 = read frame; sampled with start.
REQ-007 addr  input  7  register address; sampled with start.
REQ-008 wr_data  input  8  write payload; sampled with start (sent for reads too).
REQ-009 busy  output  1  high from the cycle after acceptance until the cycle done is high.
REQ-010 done  output  1  one-cycle completion pulse.
REQ-011 rd_data  output  8  last 8 CIPO bits captured in the frame; valid when done=1, held until the next done.
REQ-012 nCS  output  1  active-low chip select.
REQ-013 SCLK  output  1  serial clock, idle low.
REQ-014 COPI  output  1  serial data to target.
REQ-015 CIPO  input  1  serial data from target.

Function
REQ-016 SHALL implement FSM states IDLE, SETUP, SHIFT, GAP; all outputs registered.
REQ-017 Frame SHALL be 16 bits, MSB first: {rw, addr[6:0], wr_data[7:0]}, latched into a shift register when start=1 in IDLE (cycle 0).
REQ-018 IDLE->SETUP on accepted start; from cycle 1: nCS=0, busy=1, SCLK=0, COPI=frame[15].
REQ-019 SETUP SHALL last HALF_PERIOD cycles, then enter SHIFT.
REQ-020 SHIFT: each bit = HALF_PERIOD cycles SCLK=1 followed by HALF_PERIOD cycles SCLK=0 (mode 0); 16 bits, 32*HALF_PERIOD cycles.
REQ-021 CIPO SHALL be sampled into rd shift register on the clk edge where SCLK goes 0->1; rd_data takes the bits from rising edges 9..16, MSB first.
REQ-022 COPI SHALL advance to the next frame bit on the edge where SCLK goes 1->0; after the 16th falling edge COPI=0.
REQ-023 After the 16th low half, SHIFT->GAP: nCS=1, SCLK=0, busy=1 for GAP_CYCLES cycles.
REQ-024 GAP->IDLE; in that first IDLE cycle done=1, busy=0, rd_data updated; nCS low duration = 33*HALF_PERIOD cycles exactly; done at cycle 1+33*HALF_PERIOD+GAP_CYCLES.
REQ-025 start while busy=1 SHALL be ignored, with no effect on the frame in progress or on latched inputs.
REQ-026 start high in the done cycle SHALL be accepted (back-to-back); no start SHALL ever be queued.
REQ-027 Half-period and bit counters SHALL wrap to 0 at terminal count; no counter SHALL exceed its range.

Reset
REQ-028 rst_n=0 SHALL asynchronously force IDLE, nCS=1, SCLK=0, COPI=0, busy=0, done=0, rd_data=0x00, all counters and shift registers 0.
REQ-029 Reset mid-frame SHALL abort without done; first start after release SHALL begin a clean frame.

Verification
REQ-030 Write: HALF_PERIOD=4, GAP_CYCLES=8, start rw=1 addr=0x04 wr_data=0xA5 -> COPI bits 0x84A5 on 16 rising SCLK edges, nCS low 132 cycles, done at cycle 141.
REQ-031 Read: rw=0 addr=0x02, CIPO model drives 0x3C on bits 9..16 -> frame 0x02xx, rd_data=0x3C at done.
REQ-032 start pulsed at cycles 10 and 100 of a frame with different addr -> single frame with original addr, single done.
REQ-033 rst_n low at cycle 60 of a frame -> nCS=1, SCLK=0 same cycle, no done; new write after release completes normally.
REQ-034 start held high continuously -> consecutive frames with nCS high exactly GAP_CYCLES+1 cycles between them, one done per frame.
REQ-035 HALF_PERIOD=2, GAP_CYCLES=1 -> SCLK period 4 cycles, 16 pulses, done at cycle 68.
